// File: rtl/latency_sequencer_if.sv
// latency_sequencer_if
//   Signal bundle between the latency sequencer and its surroundings
//   (pattern selector, light sensor, DVI driver, display/LED logic).
//
//   Handshake semantics: there is no ready/backpressure anywhere on this
//   bundle. start and abort are single-cycle requests sampled on the rising
//   clock edge. frame_start is a single-cycle pulse per video frame.
//   light_on is a level. result_valid is a single-cycle qualifier for result.
//   result holds its value between pulses.
//
//   slave  : the sequencer side (consumes requests, produces status/result)
//   master : the environment side (produces requests, consumes status/result)
interface latency_sequencer_if;
  logic        start;
  logic        abort;
  logic        frame_start;
  logic        light_on;
  logic [3:0]  pattern_in;
  logic [3:0]  pattern_out;
  logic        busy;
  logic        result_valid;
  logic [15:0] result;
  logic        timeout;

  modport slave (
    input  start, abort, frame_start, light_on, pattern_in,
    output pattern_out, busy, result_valid, result, timeout
  );

  modport master (
    output start, abort, frame_start, light_on, pattern_in,
    input  pattern_out, busy, result_valid, result, timeout
  );
endinterface

// File: rtl/latency_sequencer.sv
// latency_sequencer
//   Display latency measurement controller. On start it takes over the DVI
//   test pattern and runs 2^RUNS_LOG2 dark->flash cycles. Each run counts
//   ticks from the frame boundary where white is shown until the light
//   sensor reports light. The truncated average of the runs is reported.
//
// Ports:
//   clk        system clock (all signals in this domain)
//   resetn     asynchronous active-low reset
//   bus        slave side of latency_sequencer_if:
//                start/abort requests, frame_start pulse, light_on level,
//                pattern_in passthrough, pattern_out, busy, result_valid,
//                result, timeout
//   state_dbg  current FSM state (IDLE=0, DARK=1, FLASH=2, DONE=3)
module latency_sequencer #(
  parameter int         TICK_CYCLES   = 100000,
  parameter int         SETTLE_TICKS  = 200,
  parameter int         TIMEOUT_TICKS = 2000,
  parameter int         RUNS_LOG2     = 3,
  parameter logic [3:0] PAT_BLACK     = 4'd0,
  parameter logic [3:0] PAT_WHITE     = 4'd1
) (
  input  logic                       clk,
  input  logic                       resetn,
  latency_sequencer_if.slave         bus,
  output logic [1:0]                 state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DARK  = 2'd1,
    S_FLASH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int AW = 16 + RUNS_LOG2;
  localparam int RW = RUNS_LOG2 + 1;

  localparam logic [PW-1:0] PRESCALE_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [15:0]   SETTLE_T      = 16'(SETTLE_TICKS);
  localparam logic [15:0]   TIMEOUT_T     = 16'(TIMEOUT_TICKS);
  localparam logic [RW-1:0] LAST_RUN      = RW'((1 << RUNS_LOG2) - 1);

  state_t        state, state_n;
  logic [PW-1:0] prescale;
  logic [15:0]   tick;
  logic [AW-1:0] acc;
  logic [RW-1:0] run_cnt;
  logic [15:0]   result_q;
  logic          timeout_q;

  // Control strobes from the next-state logic.
  logic          begin_meas;   // start accepted in IDLE
  logic          restart_cnt;  // entering DARK or FLASH: clear prescaler/tick
  logic          take_sample;  // light seen in FLASH
  logic          finish;       // last sample taken: publish result
  logic          time_out;     // tick limit hit without a sample

  logic [AW-1:0] acc_sum;
  logic          last_run;

  // Sum including the sample of this cycle, so the result published on the
  // transition into DONE already contains the final run.
  assign acc_sum  = acc + AW'(tick);
  assign last_run = (run_cnt == LAST_RUN);

  // --------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // --------------------------------------------------------------------
  // Next-state logic. abort wins over every other exit of a busy state.
  // --------------------------------------------------------------------
  always_comb begin
    state_n     = state;
    begin_meas  = 1'b0;
    restart_cnt = 1'b0;
    take_sample = 1'b0;
    finish      = 1'b0;
    time_out    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_n     = S_DARK;
          begin_meas  = 1'b1;
          restart_cnt = 1'b1;
        end
      end
      S_DARK: begin
        if (bus.abort) begin
          state_n = S_IDLE;
        end else if (tick >= TIMEOUT_T) begin
          state_n  = S_IDLE;
          time_out = 1'b1;
        end else if (tick >= SETTLE_T && !bus.light_on && bus.frame_start) begin
          state_n     = S_FLASH;
          restart_cnt = 1'b1;
        end
      end
      S_FLASH: begin
        if (bus.abort) begin
          state_n = S_IDLE;
        end else if (bus.light_on) begin
          // A sample in the same cycle as the limit tick still counts.
          take_sample = 1'b1;
          if (last_run) begin
            state_n = S_DONE;
            finish  = 1'b1;
          end else begin
            state_n     = S_DARK;
            restart_cnt = 1'b1;
          end
        end else if (tick >= TIMEOUT_T) begin
          state_n  = S_IDLE;
          time_out = 1'b1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------
  // Prescaler and tick counter. They run in DARK and FLASH and restart on
  // every entry to either state.
  // --------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prescale <= '0;
      tick     <= '0;
    end else if (restart_cnt) begin
      prescale <= '0;
      tick     <= '0;
    end else if (state == S_DARK || state == S_FLASH) begin
      if (prescale == PRESCALE_LAST) begin
        prescale <= '0;
        // Saturate so the counter can never wrap back below the limit.
        if (tick != 16'hFFFF) begin
          tick <= tick + 16'd1;
        end
      end else begin
        prescale <= prescale + PW'(1);
      end
    end
  end

  // --------------------------------------------------------------------
  // Accumulator, run counter, result and timeout flag
  // --------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc       <= '0;
      run_cnt   <= '0;
      result_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (begin_meas) begin
        acc     <= '0;
        run_cnt <= '0;
      end else if (take_sample) begin
        acc     <= acc_sum;
        run_cnt <= run_cnt + RW'(1);
      end

      if (finish) begin
        result_q <= acc_sum[AW-1:RUNS_LOG2];
      end

      if (begin_meas) begin
        timeout_q <= 1'b0;
      end else if (time_out) begin
        timeout_q <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------
  always_comb begin
    bus.pattern_out = bus.pattern_in;
    case (state)
      S_IDLE:  bus.pattern_out = bus.pattern_in;
      S_DARK:  bus.pattern_out = PAT_BLACK;
      S_FLASH: bus.pattern_out = PAT_WHITE;
      S_DONE:  bus.pattern_out = PAT_BLACK;
      default: bus.pattern_out = bus.pattern_in;
    endcase
  end

  assign bus.busy         = (state != S_IDLE);
  assign bus.result_valid = (state == S_DONE);
  assign bus.result       = result_q;
  assign bus.timeout      = timeout_q;
  assign state_dbg        = state;

endmodule

// File: tb/tb_latency_sequencer.sv
// tb_latency_sequencer
//   Directed bench for latency_sequencer with TICK_CYCLES=10, SETTLE_TICKS=3,
//   TIMEOUT_TICKS=50, RUNS_LOG2=2 and a frame_start pulse every 40 cycles.
//   Inputs change and outputs are sampled on the falling clock edge.
module tb_latency_sequencer;

  localparam logic [3:0] USER_PAT = 4'h5;

  logic       clk;
  logic       resetn;
  logic [1:0] state_dbg;

  int checks    = 0;
  int errors    = 0;
  int rv_count  = 0;

  latency_sequencer_if bus ();

  latency_sequencer #(
    .TICK_CYCLES  (10),
    .SETTLE_TICKS (3),
    .TIMEOUT_TICKS(50),
    .RUNS_LOG2    (2),
    .PAT_BLACK    (4'd0),
    .PAT_WHITE    (4'd1)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus.slave),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- frame pulse generator ----------------
  initial begin
    int fc;
    fc = 1;
    bus.frame_start = 1'b0;
    forever begin
      @(negedge clk);
      fc = (fc == 39) ? 0 : fc + 1;
      bus.frame_start = (fc == 0);
    end
  end

  // ---------------- result_valid pulse counter ----------------
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (bus.result_valid === 1'b1) rv_count++;
    end
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Pulse start; returns at the falling edge of the first DARK cycle.
  task automatic do_start(input string tag);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_busy"}, bus.busy, 1);
    check({tag, "_pat_dark"}, bus.pattern_out, 0);
    check({tag, "_timeout_clr"}, bus.timeout, 0);
  endtask

  // Wait for FLASH; 'already' is the number of cycles since DARK entry.
  // FLASH cannot come before 3 settle ticks plus the frame acceptance cycle,
  // and must come within one frame period after that.
  task automatic wait_flash(input string tag, input int already);
    int cnt;
    cnt = already;
    while (bus.pattern_out !== 4'd1 && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, "_flash_entry"}, bus.pattern_out, 1);
    check({tag, "_settle_window"}, (cnt >= 31 && cnt <= 71), 1);
  endtask

  // One run: light rises d cycles after FLASH entry and stays high 20 cycles.
  task automatic run_flash(input string tag, input int already, input int d,
                           input bit last, input logic [15:0] exp_res);
    wait_flash(tag, already);
    repeat (d) @(negedge clk);
    bus.light_on = 1'b1;
    @(negedge clk);
    check({tag, "_pat_after_sample"}, bus.pattern_out, 0);
    check({tag, "_busy_after_sample"}, bus.busy, 1);
    if (last) begin
      check({tag, "_rv_done"}, bus.result_valid, 1);
      check({tag, "_result"}, bus.result, 32'(exp_res));
      @(negedge clk);
      check({tag, "_busy_p2"}, bus.busy, 0);
      check({tag, "_rv_p2"}, bus.result_valid, 0);
      check({tag, "_pat_p2"}, bus.pattern_out, 32'(USER_PAT));
      check({tag, "_timeout"}, bus.timeout, 0);
      repeat (18) @(negedge clk);
    end else begin
      check({tag, "_rv_mid"}, bus.result_valid, 0);
      repeat (19) @(negedge clk);
    end
    bus.light_on = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    resetn          = 1'b0;
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.light_on    = 1'b0;
    bus.pattern_in  = USER_PAT;

    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_rv", bus.result_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_timeout", bus.timeout, 0);
    check("rst_pat", bus.pattern_out, 32'(USER_PAT));
    check("rst_state", state_dbg, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Constant delay: 125 cycles -> tick 12 each run, average 12.
    do_start("const");
    run_flash("const_r1", 0, 125, 1'b0, 16'd0);
    run_flash("const_r2", 19, 125, 1'b0, 16'd0);
    run_flash("const_r3", 19, 125, 1'b0, 16'd0);
    run_flash("const_r4", 19, 125, 1'b1, 16'd12);
    check("const_rv_count", rv_count, 1);

    // Averaging: ticks 5,10,15,20 -> sum 50 -> 12 truncated.
    do_start("avg");
    run_flash("avg_r1", 0, 51, 1'b0, 16'd0);
    run_flash("avg_r2", 19, 101, 1'b0, 16'd0);
    run_flash("avg_r3", 19, 151, 1'b0, 16'd0);
    run_flash("avg_r4", 19, 201, 1'b1, 16'd12);
    check("avg_rv_count", rv_count, 2);

    // Ignored start while busy: still exactly four runs, ticks 8 -> 8.
    do_start("ign");
    run_flash("ign_r1", 0, 85, 1'b0, 16'd0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("ign_busy_kept", bus.busy, 1);
    run_flash("ign_r2", 20, 85, 1'b0, 16'd0);
    run_flash("ign_r3", 19, 85, 1'b0, 16'd0);
    run_flash("ign_r4", 19, 85, 1'b1, 16'd8);
    check("ign_rv_count", rv_count, 3);

    // Flash timeout: light never rises; tick 50 reached 500 cycles in.
    do_start("fto");
    wait_flash("fto", 0);
    repeat (500) @(negedge clk);
    check("fto_busy_at_limit", bus.busy, 1);
    check("fto_timeout_before", bus.timeout, 0);
    @(negedge clk);
    check("fto_busy", bus.busy, 0);
    check("fto_timeout", bus.timeout, 1);
    check("fto_pat", bus.pattern_out, 32'(USER_PAT));
    check("fto_result_kept", bus.result, 8);
    check("fto_rv_count", rv_count, 3);

    // Dark timeout: light held high, DARK never flashes.
    bus.light_on = 1'b1;
    do_start("dto");
    repeat (500) @(negedge clk);
    check("dto_busy_at_limit", bus.busy, 1);
    @(negedge clk);
    check("dto_busy", bus.busy, 0);
    check("dto_timeout", bus.timeout, 1);
    check("dto_pat", bus.pattern_out, 32'(USER_PAT));
    check("dto_result_kept", bus.result, 8);
    bus.light_on = 1'b0;
    do_start("dto_restart");
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_dark_busy", bus.busy, 0);

    // Abort mid-FLASH.
    do_start("abt");
    wait_flash("abt", 0);
    repeat (50) @(negedge clk);
    check("abt_in_flash", bus.pattern_out, 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abt_busy", bus.busy, 0);
    check("abt_pat", bus.pattern_out, 32'(USER_PAT));
    check("abt_timeout", bus.timeout, 0);
    check("abt_result_kept", bus.result, 8);
    repeat (3) @(negedge clk);
    check("abt_rv_count", rv_count, 3);

    // start and abort together in IDLE.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("sa_busy", bus.busy, 0);
    check("sa_state", state_dbg, 0);

    // Reset mid-run during the second FLASH.
    do_start("rst");
    run_flash("rst_r1", 0, 125, 1'b0, 16'd0);
    wait_flash("rst_r2", 19);
    repeat (20) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("mrst_busy", bus.busy, 0);
    check("mrst_rv", bus.result_valid, 0);
    check("mrst_result", bus.result, 0);
    check("mrst_timeout", bus.timeout, 0);
    check("mrst_pat", bus.pattern_out, 32'(USER_PAT));
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    check("mrst_idle", state_dbg, 0);

    do_start("post");
    run_flash("post_r1", 0, 125, 1'b0, 16'd0);
    run_flash("post_r2", 19, 125, 1'b0, 16'd0);
    run_flash("post_r3", 19, 125, 1'b0, 16'd0);
    run_flash("post_r4", 19, 125, 1'b1, 16'd12);
    check("post_rv_count", rv_count, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
